// File: rtl/core_alu_latched.sv
// 8-bit 6502/2A03-style ALU with combinational N/V/Z/C and an enable-gated output register.
// Define CORE_ALU_DECIMAL_EN to add the I_decimal port and BCD-corrected ADC/SBC.
module core_alu_latched #(
    parameter logic [7:0] RESET_RESULT = 8'h00,
    parameter logic [3:0] RESET_FLAGS  = 4'h0
) (
    input  logic       I_clock,
    input  logic       I_reset,
    input  logic       I_enable,
    input  logic [3:0] I_control,
    input  logic [3:0] I_mask_p,
    input  logic [7:0] I_lhs,
    input  logic [7:0] I_rhs,
    input  logic       I_carry,
    input  logic       I_overflow,
    input  logic       I_sign,
    input  logic       I_zero,
`ifdef CORE_ALU_DECIMAL_EN
    input  logic       I_decimal,
`endif
    output logic [7:0] O_result,
    output logic       O_carry,
    output logic       O_overflow,
    output logic       O_sign,
    output logic       O_zero,
    output logic [7:0] Q_result,
    output logic [3:0] Q_flags
);

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_OR  = 4'd1,
        OP_AND = 4'd2,
        OP_EOR = 4'd3,
        OP_ADC = 4'd4,
        OP_SBC = 4'd5,
        OP_CMP = 4'd6,
        OP_ASL = 4'd7,
        OP_LSR = 4'd8,
        OP_ROL = 4'd9,
        OP_ROR = 4'd10,
        OP_INC = 4'd11,
        OP_DEC = 4'd12,
        OP_BIT = 4'd13,
        OP_LDA = 4'd14,
        OP_RSV = 4'd15
    } op_e;

    op_e        op;
    logic [7:0] addend;
    logic       add_cin;
    logic [8:0] sum;
    logic [7:0] ovf_vec;
    logic       add_v;
    logic [7:0] arith_r;
    logic       arith_c;

    logic [7:0] res;
    logic       c_op;
    logic       v_op;
    logic       n_op;
    logic       z_op;

    logic [7:0] result_q;
    logic [7:0] result_d;
    logic [3:0] flags_q;
    logic [3:0] flags_d;

    assign op = op_e'(I_control);

    // SBC and CMP share the adder by inverting rhs; CMP forces carry-in.
    always_comb begin
        addend  = I_rhs;
        add_cin = I_carry;
        if (op == OP_SBC || op == OP_CMP) begin
            addend = ~I_rhs;
        end
        if (op == OP_CMP) begin
            add_cin = 1'b1;
        end
        sum     = {1'b0, I_lhs} + {1'b0, addend} + {8'd0, add_cin};
        ovf_vec = ~(I_lhs ^ addend) & (I_lhs ^ sum[7:0]);
        add_v   = ovf_vec[7];
    end

`ifdef CORE_ALU_DECIMAL_EN
    logic [4:0] lo_raw;
    logic [4:0] hi_raw;
    logic       lo_c;
    logic       hi_c;
    logic [3:0] lo_dig;
    logic [3:0] hi_dig;

    // Nibble-wise BCD fixup; N/V/Z still come from the binary sum.
    always_comb begin
        lo_raw  = 5'd0;
        hi_raw  = 5'd0;
        lo_c    = 1'b0;
        hi_c    = 1'b0;
        lo_dig  = 4'd0;
        hi_dig  = 4'd0;
        arith_r = sum[7:0];
        arith_c = sum[8];
        if (I_decimal && op == OP_ADC) begin
            lo_raw  = {1'b0, I_lhs[3:0]} + {1'b0, I_rhs[3:0]} + {4'd0, I_carry};
            lo_c    = (lo_raw > 5'd9);
            lo_dig  = lo_c ? (lo_raw[3:0] + 4'd6) : lo_raw[3:0];
            hi_raw  = {1'b0, I_lhs[7:4]} + {1'b0, I_rhs[7:4]} + {4'd0, lo_c};
            hi_c    = (hi_raw > 5'd9);
            hi_dig  = hi_c ? (hi_raw[3:0] + 4'd6) : hi_raw[3:0];
            arith_r = {hi_dig, lo_dig};
            arith_c = hi_c;
        end else if (I_decimal && op == OP_SBC) begin
            lo_raw  = {1'b0, I_lhs[3:0]} - {1'b0, I_rhs[3:0]} - {4'd0, ~I_carry};
            lo_c    = lo_raw[4];
            lo_dig  = lo_c ? (lo_raw[3:0] - 4'd6) : lo_raw[3:0];
            hi_raw  = {1'b0, I_lhs[7:4]} - {1'b0, I_rhs[7:4]} - {4'd0, lo_c};
            hi_c    = hi_raw[4];
            hi_dig  = hi_c ? (hi_raw[3:0] - 4'd6) : hi_raw[3:0];
            arith_r = {hi_dig, lo_dig};
            arith_c = ~hi_c;
        end
    end
`else
    always_comb begin
        arith_r = sum[7:0];
        arith_c = sum[8];
    end
`endif

    always_comb begin
        res  = I_lhs;
        c_op = I_carry;
        v_op = I_overflow;
        n_op = I_sign;
        z_op = I_zero;
        unique case (op)
            OP_OR: res = I_lhs | I_rhs;
            OP_AND: res = I_lhs & I_rhs;
            OP_EOR: res = I_lhs ^ I_rhs;
            OP_ADC, OP_SBC: begin
                res  = arith_r;
                c_op = arith_c;
                v_op = add_v;
            end
            OP_CMP: begin
                res  = sum[7:0];
                c_op = sum[8];
            end
            OP_ASL: begin
                res  = {I_lhs[6:0], 1'b0};
                c_op = I_lhs[7];
            end
            OP_LSR: begin
                res  = {1'b0, I_lhs[7:1]};
                c_op = I_lhs[0];
            end
            OP_ROL: begin
                res  = {I_lhs[6:0], I_carry};
                c_op = I_lhs[7];
            end
            OP_ROR: begin
                res  = {I_carry, I_lhs[7:1]};
                c_op = I_lhs[0];
            end
            OP_INC: res = I_lhs + 8'd1;
            OP_DEC: res = I_lhs - 8'd1;
            OP_BIT: begin
                res  = I_lhs & I_rhs;
                v_op = I_rhs[6];
            end
            OP_LDA: res = I_rhs;
            default: res = I_lhs;
        endcase

        // Flags derived from the binary sum in decimal mode.
        if (op != OP_NOP && op != OP_RSV) begin
            if (op == OP_ADC || op == OP_SBC) begin
                n_op = sum[7];
                z_op = (sum[7:0] == 8'd0);
            end else begin
                n_op = res[7];
                z_op = (res == 8'd0);
            end
        end
        if (op == OP_BIT) begin
            n_op = I_rhs[7];
        end
    end

    always_comb begin
        O_result   = res;
        O_carry    = I_mask_p[0] ? c_op : I_carry;
        O_zero     = I_mask_p[1] ? z_op : I_zero;
        O_overflow = I_mask_p[2] ? v_op : I_overflow;
        O_sign     = I_mask_p[3] ? n_op : I_sign;
    end

    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (I_enable) begin
            result_d = O_result;
            flags_d  = {O_sign, O_overflow, O_zero, O_carry};
        end
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            result_q <= RESET_RESULT;
            flags_q  <= RESET_FLAGS;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign Q_result = result_q;
    assign Q_flags  = flags_q;

endmodule

// File: tb/tb_core_alu_latched.sv
// Randomized and directed bench for core_alu_latched against an arithmetic reference model.
// Decimal checks are compiled only when CORE_ALU_DECIMAL_EN is defined.
module tb_core_alu_latched;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] ctrl;
    logic [3:0] mask;
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic       ci;
    logic       vi;
    logic       ni;
    logic       zi;
    logic       dec;
    logic [7:0] o_res;
    logic       o_c;
    logic       o_v;
    logic       o_n;
    logic       o_z;
    logic [7:0] q_res;
    logic [3:0] q_flags;

    logic [7:0] m_qres;
    logic [3:0] m_qflags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    core_alu_latched dut (
        .I_clock   (clk),
        .I_reset   (rst),
        .I_enable  (en),
        .I_control (ctrl),
        .I_mask_p  (mask),
        .I_lhs     (lhs),
        .I_rhs     (rhs),
        .I_carry   (ci),
        .I_overflow(vi),
        .I_sign    (ni),
        .I_zero    (zi),
`ifdef CORE_ALU_DECIMAL_EN
        .I_decimal (dec),
`endif
        .O_result  (o_res),
        .O_carry   (o_c),
        .O_overflow(o_v),
        .O_sign    (o_n),
        .O_zero    (o_z),
        .Q_result  (q_res),
        .Q_flags   (q_flags)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {result[7:0], N, V, Z, C}
    function automatic logic [11:0] ref_alu(input int op, input int a,
                                            input int b, input bit c_in,
                                            input bit v_in, input bit n_in,
                                            input bit z_in,
                                            input logic [3:0] m);
        int r;
        int bb;
        int s;
        int sa;
        int sb;
        int ss;
        bit c;
        bit v;
        bit n;
        bit z;
        bit nz;
        c  = c_in;
        v  = v_in;
        n  = n_in;
        z  = z_in;
        nz = 1'b1;
        r  = a;
        case (op)
            1: r = a | b;
            2: r = a & b;
            3: r = a ^ b;
            4, 5: begin
                bb = (op == 5) ? 255 - b : b;
                s  = a + bb + int'(c_in);
                sa = (a > 127) ? a - 256 : a;
                sb = (bb > 127) ? bb - 256 : bb;
                ss = sa + sb + int'(c_in);
                r  = s % 256;
                c  = (s > 255);
                v  = (ss > 127) || (ss < -128);
            end
            6: begin
                r = (a - b + 256) % 256;
                c = (a >= b);
            end
            7: begin
                r = (a * 2) % 256;
                c = (a >= 128);
            end
            8: begin
                r = a / 2;
                c = (a % 2) == 1;
            end
            9: begin
                r = (a * 2) % 256 + int'(c_in);
                c = (a >= 128);
            end
            10: begin
                r = a / 2 + 128 * int'(c_in);
                c = (a % 2) == 1;
            end
            11: r = (a + 1) % 256;
            12: r = (a + 255) % 256;
            13: begin
                r  = a & b;
                nz = 1'b0;
                z  = (r == 0);
                n  = (b >= 128);
                v  = ((b / 64) % 2) == 1;
            end
            14: r = b;
            default: begin
                r  = a;
                nz = 1'b0;
            end
        endcase
        if (nz) begin
            n = (r >= 128);
            z = (r == 0);
        end
        if (!m[0]) c = c_in;
        if (!m[1]) z = z_in;
        if (!m[2]) v = v_in;
        if (!m[3]) n = n_in;
        return {8'(r), n, v, z, c};
    endfunction

    task automatic step(input int op, input int a, input int b, input bit c_in,
                        input bit v_in, input bit n_in, input bit z_in,
                        input logic [3:0] m, input bit e, input bit r_in,
                        input string tag);
        logic [11:0] exp;
        ctrl = 4'(op);
        lhs  = 8'(a);
        rhs  = 8'(b);
        ci   = c_in;
        vi   = v_in;
        ni   = n_in;
        zi   = z_in;
        mask = m;
        en   = e;
        rst  = r_in;
        #1;
        exp = ref_alu(op, a, b, c_in, v_in, n_in, z_in, m);
        check({tag, "_res"}, 16'(o_res), 16'(exp[11:4]));
        check({tag, "_nvzc"}, 16'({o_n, o_v, o_z, o_c}), 16'(exp[3:0]));
        if (r_in) begin
            m_qres   = 8'h00;
            m_qflags = 4'h0;
        end else if (e) begin
            m_qres   = exp[11:4];
            m_qflags = exp[3:0];
        end
        @(posedge clk);
        #1;
        check({tag, "_qres"}, 16'(q_res), 16'(m_qres));
        check({tag, "_qflags"}, 16'(q_flags), 16'(m_qflags));
    endtask

    initial begin
        dec = 1'b0;
        m_qres = 8'h00;
        m_qflags = 4'h0;
        @(posedge clk);
        #1;
        step(0, 8'h33, 0, 1, 1, 1, 1, 4'hF, 1, 1, "reset");
        check("reset_q", 16'({q_res, q_flags}), 16'h0);

        step(4, 8'h50, 8'h50, 0, 0, 0, 0, 4'hF, 1, 0, "adc_ovf");
        check("adc_ovf_k", 16'({o_res, o_n, o_v, o_z, o_c}), 16'hA0C);
        step(5, 8'h00, 8'h01, 1, 0, 0, 0, 4'hF, 1, 0, "sbc_borrow");
        check("sbc_k", 16'({o_res, o_n, o_v, o_z, o_c}), 16'hFF8);
        step(6, 8'h42, 8'h42, 0, 1, 1, 0, 4'hF, 1, 0, "cmp_eq");
        check("cmp_k", 16'({o_n, o_v, o_z, o_c}), 16'h7);
        step(13, 8'h0F, 8'hC0, 0, 0, 0, 0, 4'hF, 1, 0, "bit");
        step(10, 8'h01, 0, 1, 0, 0, 0, 4'hF, 1, 0, "ror");
        step(11, 8'hFF, 0, 1, 0, 0, 0, 4'hF, 1, 0, "inc_wrap");
        step(12, 8'h00, 0, 0, 0, 0, 1, 4'hF, 1, 0, "dec_wrap");
        step(4, 8'hFF, 8'h01, 0, 0, 1, 0, 4'b0010, 1, 0, "mask_z");
        check("mask_k", 16'({o_res, o_n, o_v, o_z, o_c}), 16'h00A);

        step(14, 0, 8'h5A, 0, 0, 0, 0, 4'hF, 1, 0, "load");
        check("load_q", 16'(q_res), 16'h5A);
        step(1, 8'h12, 8'h81, 1, 1, 0, 1, 4'hF, 0, 0, "hold1");
        step(7, 8'hC3, 8'h00, 0, 0, 1, 0, 4'hF, 0, 0, "hold2");
        check("hold_q", 16'(q_res), 16'h5A);
        step(14, 0, 8'hA5, 1, 1, 1, 1, 4'hF, 1, 1, "rst_en");
        check("rst_en_q", 16'({q_res, q_flags}), 16'h0);

`ifdef CORE_ALU_DECIMAL_EN
        dec = 1'b1;
        ctrl = 4'd4;
        mask = 4'hF;
        en = 1'b0;
        rst = 1'b0;
        ci = 1'b0;
        lhs = 8'h19;
        rhs = 8'h28;
        #1;
        check("bcd_19_28", 16'({o_res, o_c}), 16'h08E);
        lhs = 8'h99;
        rhs = 8'h01;
        #1;
        check("bcd_99_01", 16'({o_res, o_c}), 16'h001);
        dec = 1'b0;
        @(posedge clk);
        #1;
`endif

        for (int i = 0; i < 300; i++) begin
            step(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 4'($urandom),
                 1'($urandom), ($urandom_range(0, 15) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
